// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: opcode encoding and fixed field widths for the CPU ALU.
package cpu_alu_pkg;

  localparam int OP_W    = 4;
  localparam int SHAMT_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_MUL = 4'b0101,
    OP_DIV = 4'b0110,
    OP_OR  = 4'b0111,
    OP_AND = 4'b1000,
    OP_XOR = 4'b1001,
    OP_SLL = 4'b1010,
    OP_SRL = 4'b1011,
    OP_SLT = 4'b1100,
    OP_SRA = 4'b1101
  } alu_op_e;

endpackage

// File: rtl/cpu_alu_muldiv.sv
// cpu_alu_muldiv: combinational unsigned multiply and divide.
// A zero divisor yields an all-ones quotient and the dividend as remainder.
module cpu_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // divide, with the divide-by-zero result substituted instead of trapping
  always_comb begin
    quotient  = '1;
    remainder = a;
    if (b != '0) begin
      quotient  = a / b;
      remainder = a % b;
    end
  end

endmodule

// File: rtl/cpu_alu.sv
// cpu_alu: 32-bit integer ALU with combinational result/zero and
// MIPS-style Hi/Lo/remain side registers for MUL and DIV.
// Optional feature macro: ALU_SRA_EN enables opcode 1101 as arithmetic shift right.
module cpu_alu
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rda,
  input  logic [WIDTH-1:0] rdx,
  input  logic [OP_W-1:0]  alu_decode,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] remain
);

  localparam int SH_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic [SH_W-1:0]    shamt;

  assign shamt = rdx[SH_W-1:0];

  cpu_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .a         (rda),
    .b         (rdx),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // opcode mux; unused codes fall through to zero
  always_comb begin
    result = '0;
    case (alu_op_e'(alu_decode))
      OP_ADD: result = rda + rdx;
      OP_SUB: result = rda - rdx;
      OP_MUL: result = product[WIDTH-1:0];
      OP_DIV: result = quotient;
      OP_OR:  result = rda | rdx;
      OP_AND: result = rda & rdx;
      OP_XOR: result = rda ^ rdx;
      OP_SLL: result = rda << shamt;
      OP_SRL: result = rda >> shamt;
      OP_SLT: result = {{(WIDTH-1){1'b0}}, (rda < rdx)};
`ifdef ALU_SRA_EN
      OP_SRA: result = $signed(rda) >>> shamt;
`endif
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // side registers: MUL loads Hi/Lo, DIV loads Lo/Hi/remain, others hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Hi     <= '0;
      Lo     <= '0;
      remain <= '0;
    end else begin
      case (alu_op_e'(alu_decode))
        OP_MUL: begin
          Hi <= product[2*WIDTH-1:WIDTH];
          Lo <= product[WIDTH-1:0];
        end
        OP_DIV: begin
          Lo     <= quotient;
          Hi     <= remainder;
          remain <= remainder;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_alu.sv
// tb_cpu_alu: directed vector table, register sequences and random checks
// against a plain-arithmetic reference model.
module tb_cpu_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rda = '0, rdx = '0;
  logic [3:0]  alu_decode = '0;
  logic [31:0] result, Hi, Lo, remain;
  logic        zero;

  int tests = 0, fails = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_rem = '0;

  always #5 clk = ~clk;

  cpu_alu dut (
    .clk(clk), .rst_n(rst_n), .rda(rda), .rdx(rdx), .alu_decode(alu_decode),
    .result(result), .zero(zero), .Hi(Hi), .Lo(Lo), .remain(remain)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned p;
    int s;
    p = longint'(a) * longint'(b);
    s = int'(b % 32);
    case (op)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd5:  return p[31:0];
      4'd6:  return (b == 0) ? 32'hFFFFFFFF : a / b;
      4'd7:  return a | b;
      4'd8:  return a & b;
      4'd9:  return a ^ b;
      4'd10: return a * (32'd1 << s);
      4'd11: return a / (32'd1 << s);
      4'd12: return (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_SRA_EN
      4'd13: return (a / (32'd1 << s)) | (a[31] ? ~(32'hFFFFFFFF / (32'd1 << s)) : 32'd0);
`endif
      default: return 32'd0;
    endcase
  endfunction

  // model of the side registers at a clock edge
  task automatic ref_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    if (op == 4'd5) begin
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (op == 4'd6) begin
      m_lo  = (b == 0) ? 32'hFFFFFFFF : a / b;
      m_rem = (b == 0) ? a : a % b;
      m_hi  = m_rem;
    end
  endtask

  // apply one op, check combinational outputs, clock it, check registers
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] e;
    alu_decode = op; rda = a; rdx = b;
    #1;
    e = ref_res(op, a, b);
    chk({name, ".result"}, result, e);
    chk({name, ".zero"}, {31'd0, zero}, {31'd0, e == 0});
    @(posedge clk);
    ref_edge(op, a, b);
    #1;
    chk({name, ".Hi"}, Hi, m_hi);
    chk({name, ".Lo"}, Lo, m_lo);
    chk({name, ".remain"}, remain, m_rem);
  endtask

  vec_t vt[$];

  initial begin
    vt.push_back('{4'b0001, 32'd5, 32'd3, 32'd8, 1'b0});
    vt.push_back('{4'b0010, 32'd5, 32'd3, 32'd2, 1'b0});
    vt.push_back('{4'b0111, 32'h55, 32'hAA, 32'hFF, 1'b0});
    vt.push_back('{4'b1000, 32'h55, 32'hAA, 32'h0, 1'b1});
    vt.push_back('{4'b1001, 32'h55, 32'hAA, 32'hFF, 1'b0});
    vt.push_back('{4'b0101, 32'd5, 32'd3, 32'd15, 1'b0});
    vt.push_back('{4'b0110, 32'd10, 32'd2, 32'd5, 1'b0});
    vt.push_back('{4'b0110, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0});
    vt.push_back('{4'b1010, 32'h80000000, 32'h10, 32'h0, 1'b1});
    vt.push_back('{4'b1011, 32'h00F0F0F0, 32'd5, 32'h00078787, 1'b0});
    vt.push_back('{4'b1011, 32'h12345678, 32'd1, 32'h091A2B3C, 1'b0});
    vt.push_back('{4'b1100, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1});
    vt.push_back('{4'b1100, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0});
    vt.push_back('{4'b1010, 32'd1, 32'hFFFFFFE3, 32'd8, 1'b0});
    vt.push_back('{4'b0001, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1});
    vt.push_back('{4'b0010, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0});
`ifdef ALU_SRA_EN
    vt.push_back('{4'b1101, 32'h80000000, 32'd4, 32'hF8000000, 1'b0});
`else
    vt.push_back('{4'b1101, 32'h80000000, 32'd4, 32'h0, 1'b1});
`endif
    vt.push_back('{4'b0000, 32'h80000000, 32'd4, 32'h0, 1'b1});
    vt.push_back('{4'b1111, 32'd9, 32'd9, 32'h0, 1'b1});

    // reset state
    #2;
    chk("reset.Hi", Hi, 0);
    chk("reset.Lo", Lo, 0);
    chk("reset.remain", remain, 0);

    // reset held through a MUL edge keeps registers cleared
    alu_decode = 4'b0101; rda = 32'd7; rdx = 32'd9;
    @(posedge clk); #1;
    chk("rst_over_mul.Lo", Lo, 0);
    alu_decode = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // table: combinational checks only
    foreach (vt[i]) begin
      alu_decode = vt[i].op; rda = vt[i].a; rdx = vt[i].b;
      #1;
      chk($sformatf("vec%0d.result", i), result, vt[i].res);
      chk($sformatf("vec%0d.zero", i), {31'd0, zero}, {31'd0, vt[i].z});
    end
    @(negedge clk);

    // register sequences
    run_op("mul5x3", 4'b0101, 32'd5, 32'd3);
    chk("mul5x3.Lo_const", Lo, 32'd15);
    chk("mul5x3.Hi_const", Hi, 32'd0);
    run_op("div10by2", 4'b0110, 32'd10, 32'd2);
    chk("div10by2.Lo_const", Lo, 32'd5);
    chk("div10by2.rem_const", remain, 32'd0);
    run_op("div7by0", 4'b0110, 32'd7, 32'd0);
    chk("div7by0.Lo_const", Lo, 32'hFFFFFFFF);
    chk("div7by0.rem_const", remain, 32'd7);
    run_op("mul_big", 4'b0101, 32'h10000, 32'h10000);
    chk("mul_big.Hi_const", Hi, 32'd1);
    chk("mul_big.Lo_const", Lo, 32'd0);
    chk("mul_big.rem_hold", remain, 32'd7);
    run_op("hold_add", 4'b0001, 32'd1, 32'd2);
    chk("hold_add.Hi_const", Hi, 32'd1);
    run_op("div_rem", 4'b0110, 32'd23, 32'd5);

    // async reset mid-cycle, before the next edge
    @(negedge clk);
    alu_decode = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("async_rst.Hi", Hi, 0);
    chk("async_rst.Lo", Lo, 0);
    chk("async_rst.remain", remain, 0);
    m_hi = 0; m_lo = 0; m_rem = 0;
    #1 rst_n = 1'b1;
    @(negedge clk);

    // randomized
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 3);
        1: b = $urandom_range(0, 40);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = $urandom_range(0, 100);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_alu.md
Name: cpu_alu

Overview:
- 32-bit integer ALU for the single-cycle CPU datapath. Combinational `result`/`zero` for all ops; MUL/DIV side results latched into Hi/Lo/remain registers (MIPS-style).
- Sits between the register file read ports (`rda`, `rdx`) and the writeback/branch logic.
- The 4-bit `alu_decode` comes from the control decoder.

Parameters:
- WIDTH, 32, data width. All behaviour below is stated for 32; shift amount is `rdx[$clog2(WIDTH)-1:0]`.

Ports:
- clk  input  1  rising-edge clock for Hi/Lo/remain registers
- rst_n  input  1  asynchronous active-low reset
- rda  input  WIDTH  operand A (shift source)
- rdx  input  WIDTH  operand B (shift amount in [4:0])
- alu_decode  input  4  operation select
- result  output  WIDTH  combinational op result
- zero  output  1  combinational, 1 when result==0
- Hi  output  WIDTH  registered upper product / DIV remainder
- Lo  output  WIDTH  registered lower product / DIV quotient
- remain  output  WIDTH  registered DIV remainder

Interface: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).

Behaviour:
- Opcodes (`alu_decode`):
  - 0001 ADD: `rda+rdx`, mod 2^32
  - 0010 SUB: `rda-rdx`, mod 2^32
  - 0101 MUL: unsigned 64-bit product P; `result`=P[31:0]
  - 0110 DIV: unsigned; `result`=quotient
  - 0111 OR
  - 1000 AND
  - 1001 XOR
  - 1010 SLL: `rda << rdx[4:0]`, zero fill
  - 1011 SRL: `rda >> rdx[4:0]`, zero fill
  - 1100 SLT: unsigned compare, `result` = (`rda<rdx`) ? 1 : 0
  - All other codes (0000, 0011, 0100, 1101-1111): `result`=0
- No overflow/carry flags. ADD/SUB wrap silently.
- `zero` = (`result`==0), combinational, valid for every opcode including the undefined codes (`zero`=1 there).
- `result`/`zero` latency is 0: purely combinational, independent of `clk`/`rst_n`.
- Hi/Lo/remain registers:
  - On rising `clk` with MUL: Hi<=P[63:32], Lo<=P[31:0]; remain holds.
  - On rising `clk` with DIV: Lo<=quotient, Hi<=remainder, remain<=remainder.
  - Any other opcode: all three hold.
- Divide by zero (`rdx`==0): quotient=32'hFFFFFFFF, remainder=`rda`. No trap.
- Reset: `rst_n` low clears Hi, Lo, remain to 0 immediately (async), regardless of clock. It overrides a simultaneous MUL/DIV edge. Deassertion is synchronised externally; the first capture is on the first rising edge with `rst_n` high.
- Shift amount uses only `rdx[4:0]`; `rdx[31:5]` ignored (shift by 32 impossible).

Optional Feature:
- ALU_SRA_EN defined: opcode 1101 = arithmetic shift right, `rda >>> rdx[4:0]`, sign fill.
- Undefined: 1101 yields `result`=0 like other unused codes.

Decomposition:
- Package cpu_alu_pkg holds:
  - enum alu_op_e (the codes above)
  - WIDTH-independent constants: opcode width 4, shift-field width 5
- One sub-module, cpu_alu_muldiv: combinational 64-bit unsigned multiply and unsigned divide with the div-by-zero rule. Outputs product, quotient, remainder.
- The top holds the opcode mux, `zero`, and the Hi/Lo/remain registers.

Test Plan:
- ADD/SUB/logic:
  - `rda`=5, `rdx`=3, 0001 -> `result`=8
  - 0010 -> `result`=2
  - `rda`=0x55, `rdx`=0xAA: 0111 -> 0xFF; 1000 -> 0, `zero`=1; 1001 -> 0xFF
- MUL/DIV:
  - `rda`=5, `rdx`=3, 0101 -> `result`=15; after `clk` edge Lo=15, Hi=0
  - `rda`=10, `rdx`=2, 0110 -> `result`=5; after edge Lo=5, remain=0, Hi=0
  - `rda`=7, `rdx`=0, 0110 -> quotient 0xFFFFFFFF, remain=7
- Shifts:
  - `rda`=0x80000000, `rdx`=0x10, 1010 -> 0, `zero`=1
  - `rda`=0x00F0F0F0, `rdx`=5, 1011 -> 0x00078787
  - `rda`=0x12345678, `rdx`=1, 1011 -> 0x091A2B3C
- SLT: `rda`=0xFFFFFFFF, `rdx`=1, 1100 -> 0 (unsigned); `rda`=1, `rdx`=0xFFFFFFFF -> 1.
- Reset/registers:
  - After MUL 0x10000*0x10000 and one edge: Hi=1, Lo=0.
  - Drop `rst_n` mid-cycle: Hi/Lo/remain=0 before the next edge.
  - A non-MUL/DIV opcode on an edge leaves the registers unchanged.
- Optional/undefined:
  - 1101 with ALU_SRA_EN, `rda`=0x80000000, `rdx`=4 -> 0xF8000000
  - Same stimulus without the macro -> 0, `zero`=1
  - 0000 -> 0
